// File: rtl/mult_pkg.sv
// Shared types and constants for the serial partial-product accumulator.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, ADD, OUT} acc_state_t;

  localparam int unsigned DIGIT_W = 2;

endpackage

// File: rtl/cla.sv
// 2-bit carry-lookahead adder slice.
module cla (
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic cin,
  output logic s0,
  output logic s1,
  output logic cout
);

  logic g0, g1, p0, p1, c1;

  // Generate/propagate terms and lookahead carries
  assign g0   = a0 & b0;
  assign g1   = a1 & b1;
  assign p0   = a0 ^ b0;
  assign p1   = a1 ^ b1;
  assign c1   = g0 | (p0 & cin);
  assign cout = g1 | (p1 & g0) | (p1 & p0 & cin);
  assign s0   = p0 ^ cin;
  assign s1   = p1 ^ c1;

endmodule

// File: rtl/pp_serial_accumulator.sv
// Digit-serial accumulator: adds shifted partial products 2 bits per cycle
// through one cla slice and presents the wrapped sum on a valid/ready port.
// Optional macro PP_ACC_OVF_FLAG_EN adds a sticky prod_ovf output.
module pp_serial_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pp_data,
  input  logic             pp_valid,
  input  logic             pp_last,
  output logic             pp_ready,
  output logic [WIDTH-1:0] prod_data,
  output logic             prod_valid,
`ifdef PP_ACC_OVF_FLAG_EN
  output logic             prod_ovf,
`endif
  input  logic             prod_ready
);

  localparam int unsigned DIGITS = WIDTH / DIGIT_W;
  localparam int unsigned K_W    = $clog2(DIGITS);

  // Elaboration-time parameter check
  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("pp_serial_accumulator: WIDTH must be even and >= 4");
  end

  acc_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             carry_q, carry_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             last_q, last_d;
  logic             prod_valid_q, prod_valid_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT_W-1:0] a_dig, b_dig, s_dig;
  logic               cout;

  // Select the current digit of acc and operand
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (k_q == K_W'(i)) begin
        a_dig = acc_q[i*DIGIT_W +: DIGIT_W];
        b_dig = operand_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  cla u_cla (
    .a0   (a_dig[0]),
    .a1   (a_dig[1]),
    .b0   (b_dig[0]),
    .b1   (b_dig[1]),
    .cin  (carry_q),
    .s0   (s_dig[0]),
    .s1   (s_dig[1]),
    .cout (cout)
  );

  // Next-state, digit write-back and handshake control
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    operand_d    = operand_q;
    carry_d      = carry_q;
    k_d          = k_q;
    last_d       = last_q;
    prod_valid_d = prod_valid_q;
    ovf_d        = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (pp_valid) begin
          state_d   = ADD;
          operand_d = pp_data;
          last_d    = pp_last;
          k_d       = '0;
          carry_d   = 1'b0;
        end
      end
      ADD: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (k_q == K_W'(i)) acc_d[i*DIGIT_W +: DIGIT_W] = s_dig;
        end
        carry_d = cout;
        k_d     = k_q + K_W'(1);
        if (k_q == K_W'(DIGITS - 1)) begin
          k_d          = '0;
          state_d      = last_q ? OUT : IDLE;
          prod_valid_d = last_q;
          if (cout) ovf_d = 1'b1;
        end
      end
      OUT: begin
        if (prod_ready) begin
          state_d      = IDLE;
          acc_d        = '0;
          prod_valid_d = 1'b0;
          ovf_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      operand_q    <= '0;
      carry_q      <= 1'b0;
      k_q          <= '0;
      last_q       <= 1'b0;
      prod_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      operand_q    <= operand_d;
      carry_q      <= carry_d;
      k_q          <= k_d;
      last_q       <= last_d;
      prod_valid_q <= prod_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign pp_ready   = (state_q == IDLE);
  assign prod_data  = acc_q;
  assign prod_valid = prod_valid_q;
`ifdef PP_ACC_OVF_FLAG_EN
  assign prod_ovf   = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pp_serial_accumulator.sv
// Scoreboard bench for pp_serial_accumulator at WIDTH=8.
module tb_pp_serial_accumulator;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pp_data;
  logic         pp_valid;
  logic         pp_last;
  logic         pp_ready;
  logic [W-1:0] prod_data;
  logic         prod_valid;
  logic         prod_ready;
`ifdef PP_ACC_OVF_FLAG_EN
  logic         prod_ovf;
`endif

  pp_serial_accumulator #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pp_data    (pp_data),
    .pp_valid   (pp_valid),
    .pp_last    (pp_last),
    .pp_ready   (pp_ready),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
`ifdef PP_ACC_OVF_FLAG_EN
    .prod_ovf   (prod_ovf),
`endif
    .prod_ready (prod_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [W:0] exp_q[$];   // {ovf, data}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every product handshake is checked against the scoreboard
  always @(negedge clk) begin
    if (!reset && prod_valid && prod_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_product", 32'(prod_data), 32'hDEAD);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("prod_data", 32'(prod_data), 32'(e[W-1:0]));
`ifdef PP_ACC_OVF_FLAG_EN
        chk("prod_ovf", 32'(prod_ovf), 32'(e[W]));
`endif
      end
    end
  end

  // Offer one partial product and return after the accepting edge
  task automatic send(input logic [W-1:0] d, input logic last, output int acc_cyc);
    bit done;
    done     = 1'b0;
    acc_cyc  = -1;
    pp_data  = d;
    pp_last  = last;
    pp_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (pp_ready) begin
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    pp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c1, c2, c3, vcnt;
    bit seen;
    reset      = 1'b1;
    pp_valid   = 1'b0;
    pp_last    = 1'b0;
    pp_data    = '0;
    prod_ready = 1'b1;
    idle(3);
    reset = 1'b0;

    // Reset state held while idle; prod_ready alone does nothing
    for (int i = 0; i < 10; i++) begin
      chk("idle_pp_ready", 32'(pp_ready), 32'd1);
      chk("idle_prod_valid", 32'(prod_valid), 32'd0);
      chk("idle_prod_data", 32'(prod_data), 32'd0);
      idle(1);
    end

    // 0x03 + 0x05 + 0x0A = 0x12, back-to-back
    exp_q.push_back({1'b0, 8'h12});
    send(8'h03, 1'b0, c1);
    send(8'h05, 1'b0, c2);
    send(8'h0A, 1'b1, c3);
    chk("accept_spacing_1", 32'(c2 - c1), 32'd5);
    chk("accept_spacing_2", 32'(c3 - c2), 32'd5);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (prod_valid) vcnt++;
      idle(1);
    end
    chk("prod_valid_cycles", 32'(vcnt), 32'd1);

    // Carry across every digit, wraps to zero
    exp_q.push_back({1'b1, 8'h00});
    send(8'h55, 1'b0, c1);
    send(8'hAB, 1'b1, c2);
    idle(8);

    // Backpressure on the product port
    prod_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h7F});
    send(8'h7F, 1'b1, c1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (prod_valid) seen = 1'b1;
      else idle(1);
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("bp_prod_valid", 32'(prod_valid), 32'd1);
      chk("bp_prod_data", 32'(prod_data), 32'h7F);
      chk("bp_pp_ready", 32'(pp_ready), 32'd0);
      idle(1);
    end
    prod_ready = 1'b1;
    idle(1);
    chk("bp_cleared_valid", 32'(prod_valid), 32'd0);
    chk("bp_cleared_acc", 32'(prod_data), 32'd0);
    exp_q.push_back({1'b0, 8'h01});
    send(8'h01, 1'b1, c1);
    idle(8);

    // Reset during the third ADD cycle abandons 0xFF
    send(8'hFF, 1'b1, c1);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("rst_pp_ready", 32'(pp_ready), 32'd1);
    chk("rst_prod_valid", 32'(prod_valid), 32'd0);
    chk("rst_prod_data", 32'(prod_data), 32'd0);
    exp_q.push_back({1'b0, 8'h02});
    send(8'h02, 1'b1, c1);
    idle(8);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
